rc4_stream_xor: RTL and testbench
=================================

Name: rc4_stream_xor

Overview:
Data-path end of the RC4 cipher. Consumes keystream bytes from the rc4 keystream generator through a valid/ready port and XORs them with an incoming byte stream. Encryption and decryption are the same operation.
Buffers keystream in a small FIFO so generator latency is hidden. Handles one message of programmable length per start, then signals done.

Parameters:
FIFO_DEPTH, 4, keystream FIFO depth in bytes; power of 2, at least 2.
LEN_W, 8, width of the message length and internal byte counters.
DROP_N, 256, number of leading keystream bytes discarded; used only when RC4_DROP_EN is defined.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that begins a message; ignored while busy=1.
msg_len  in  LEN_W  message length in bytes; latched when start is accepted.
ks_valid  in  1  keystream byte available.
ks_data  in  8  keystream byte.
ks_ready  out  1  block accepts a keystream byte.
in_valid  in  1  input (plain or cipher) byte valid.
in_data  in  8  input byte.
in_ready  out  1  block accepts an input byte.
out_valid  out  1  output byte valid.
out_data  out  8  in_data XOR keystream byte.
out_ready  in  1  downstream accepts the output byte.
busy  out  1  a message is in progress.
done  out  1  one-cycle pulse when the last output byte is accepted.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; FIFO is emptied; all counters are cleared.
  - Outputs: ks_ready=0, in_ready=0, out_valid=0, out_data=8'h00, busy=0, done=0.
  - A reset mid-message abandons the message. No partial done pulse is produced.
- States: IDLE, DROP, RUN, LAST, DONE.
- IDLE:
  - start with msg_len≠0 goes to DROP when RC4_DROP_EN is defined, otherwise to RUN. busy=1 from the next cycle.
  - start with msg_len=0 goes to DONE, with no data transfers.
- DROP:
  - ks_ready=1; every ks handshake is discarded and a drop counter increments.
  - After the DROP_N-th byte, go to RUN.
- RUN, keystream side:
  - ks_ready = FIFO not full AND ks_req_cnt < len.
  - A ks handshake pushes into the FIFO and increments ks_req_cnt.
  - Never fetches more than len bytes of keystream.
- RUN, data side:
  - in_ready = FIFO not empty AND (out_valid=0 OR out_ready=1).
  - On an in handshake, out_data <= in_data ^ FIFO head, out_valid <= 1, FIFO pops, in_cnt increments.
  - Latency is exactly 1 cycle from the in handshake to out_valid.
  - Full throughput of 1 byte/cycle is reached once the FIFO is primed.
- Output register:
  - out_data and out_valid hold stable until out_ready.
  - If out_ready=1 with no new input, out_valid drops to 0 the next cycle.
- FIFO:
  - A push and a pop in the same cycle leave the count unchanged.
  - No push when full; no pop when empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Transition to LAST: when in_cnt reaches len, go to LAST with in_ready=0.
- LAST: wait for the out handshake on the final byte, then go to DONE.
- DONE: done=1 for one cycle, busy=0 from the same cycle, next state IDLE.
- Counters are LEN_W wide; len=2^LEN_W-1 must work without overflow.
- start during busy has no effect. msg_len changes after acceptance have no effect.

Optional Feature:
RC4_DROP_EN.
- Defined: the DROP state is compiled in and the first DROP_N keystream bytes of each message are discarded (RC4-drop[N]).
- Undefined: the DROP state and drop counter are absent, IDLE goes directly to RUN, and DROP_N is unused.

Test Plan:
- Known vector, macro undefined:
  - Stimulus: msg_len=9; ks bytes EB 9F 77 81 B7 34 CA 72 A7; input "Plaintext" (50 6C 61 69 6E 74 65 78 74).
  - Required: out BB F3 16 E8 D9 40 AF 0A D3; done pulses once; busy=0 afterwards; exactly 9 ks handshakes.
- Decrypt round trip: feed the ciphertext above with the same keystream; out returns 50 6C 61 69 6E 74 65 78 74.
- Backpressure:
  - Stimulus: out_ready toggles randomly and ks_valid is gapped for the 16-byte message.
  - Required: no byte is lost or duplicated; out_data is stable while out_valid=1 and out_ready=0; the FIFO never exceeds FIFO_DEPTH.
- msg_len=0: done pulses 2 cycles after start; ks_ready and in_ready stay 0 throughout.
- Reset mid-message: rst_n=0 after 5 bytes gives all outputs 0 immediately. The next start with msg_len=3 produces correct output from fresh keystream.
- RC4_DROP_EN defined with DROP_N=4:
  - Stimulus: ks bytes 11 22 33 44 EB 9F, msg_len=2, input 50 6C.
  - Required: out BB F3.

Source files
------------

// File: rtl/rc4_stream_xor_if.sv
// Port bundle for rc4_stream_xor: start/length control, keystream in, data in, data out, status.
// Handshakes: a byte moves on a rising edge where valid=1 and ready=1; valid holds with stable data until then.
interface rc4_stream_xor_if #(
   parameter int LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] msg_len;
   logic             ks_valid;
   logic [7:0]       ks_data;
   logic             ks_ready;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_ready;
   logic             out_valid;
   logic [7:0]       out_data;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic [2:0]       state_dbg;

   modport master (
      output start, msg_len, ks_valid, ks_data, in_valid, in_data, out_ready,
      input  ks_ready, in_ready, out_valid, out_data, busy, done, state_dbg
   );

   modport slave (
      input  start, msg_len, ks_valid, ks_data, in_valid, in_data, out_ready,
      output ks_ready, in_ready, out_valid, out_data, busy, done, state_dbg
   );
endinterface

// File: rtl/rc4_stream_xor.sv
// RC4 data path: XORs an input byte stream with FIFO-buffered keystream, one message per start.
// Optional macro RC4_DROP_EN compiles in discarding of the first DROP_N keystream bytes per message.
module rc4_stream_xor #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 8,
   parameter int DROP_N     = 256
) (
   input logic             clk,
   input logic             rst_n,
   rc4_stream_xor_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DROP_N < 1) begin : g_bad_params
      $error("rc4_stream_xor: FIFO_DEPTH must be a power of 2 >= 2 and DROP_N >= 1");
   end

   typedef enum logic [2:0] {
      IDLE = 3'd0,
`ifdef RC4_DROP_EN
      DROP = 3'd1,
`endif
      RUN  = 3'd2,
      LAST = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len_q, ks_req_cnt, in_cnt;
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] fifo_cnt;
   logic             fifo_full, fifo_empty;
   logic             ks_rdy, in_rdy, push, pop, start_ok;
   logic             out_valid_q;
   logic [7:0]       out_data_q;

   assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (fifo_cnt == '0);
   assign start_ok   = (state == IDLE) && bus.start;
   assign push       = bus.ks_valid && ks_rdy && (state == RUN);
   assign pop        = bus.in_valid && in_rdy;

`ifdef RC4_DROP_EN
   localparam int DROP_W = (DROP_N > 1) ? $clog2(DROP_N) : 1;
   logic [DROP_W-1:0] drop_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_cnt <= '0;
      else if (start_ok)
         drop_cnt <= '0;
      else if (state == DROP && bus.ks_valid)
         drop_cnt <= drop_cnt + DROP_W'(1);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ks_rdy    = 1'b0;
      in_rdy    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.msg_len == '0)
                  state_nxt = DONE;
               else begin
`ifdef RC4_DROP_EN
                  state_nxt = DROP;
`else
                  state_nxt = RUN;
`endif
               end
            end
         end
`ifdef RC4_DROP_EN
         DROP: begin
            ks_rdy = 1'b1;
            if (bus.ks_valid && drop_cnt == DROP_W'(DROP_N - 1))
               state_nxt = RUN;
         end
`endif
         RUN: begin
            // Keystream fetch is capped at len so no byte leaks into the next message.
            ks_rdy = !fifo_full && (ks_req_cnt < len_q);
            in_rdy = !fifo_empty && (!out_valid_q || bus.out_ready);
            if (bus.in_valid && in_rdy && in_cnt == len_q - LEN_W'(1))
               state_nxt = LAST;
         end
         LAST: begin
            if (out_valid_q && bus.out_ready)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q      <= '0;
         ks_req_cnt <= '0;
         in_cnt     <= '0;
      end else if (start_ok) begin
         len_q      <= bus.msg_len;
         ks_req_cnt <= '0;
         in_cnt     <= '0;
      end else begin
         if (push) ks_req_cnt <= ks_req_cnt + LEN_W'(1);
         if (pop)  in_cnt     <= in_cnt + LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.ks_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Output register: a new byte may replace the old one only in the cycle it is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
      end else if (pop) begin
         out_valid_q <= 1'b1;
         out_data_q  <= bus.in_data ^ fifo_mem[rd_ptr];
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.ks_ready  = ks_rdy;
   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = (state != IDLE) && (state != DONE);
   assign bus.done      = (state == DONE);
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_rc4_stream_xor.sv
// Bench for rc4_stream_xor: random keystream/data drivers, XOR reference model, queue scoreboard.
// Build with +define+RC4_DROP_EN to exercise the keystream-drop variant (DROP_N=4 here).
module tb_rc4_stream_xor;
   localparam int LEN_W      = 8;
   localparam int FIFO_DEPTH = 4;
`ifdef RC4_DROP_EN
   localparam int TB_DROP = 4;
`else
   localparam int TB_DROP = 0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rc4_stream_xor_if #(.LEN_W(LEN_W)) bus ();

   rc4_stream_xor #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .LEN_W(LEN_W),
      .DROP_N(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // ---------------- scoreboard state ----------------
   logic [7:0] exp_q[$];
   logic [7:0] ks_src_q[$];
   logic [7:0] in_src_q[$];
   int checks = 0;
   int errors = 0;
   int done_cnt = 0, ks_hs_cnt = 0, out_hs_cnt = 0;
   int drop_left = 0, occ = 0, max_occ = 0;
   bit bp_mode = 0, gap_mode = 0;
   bit ks_fire_s = 0, in_fire_s = 0;
   bit hold_prev = 0;
   logic [7:0] hold_data = 8'h00;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor (samples on falling edge) ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         ks_fire_s = 0;
         in_fire_s = 0;
         hold_prev = 0;
      end else begin
         ks_fire_s = bus.ks_valid && bus.ks_ready;
         in_fire_s = bus.in_valid && bus.in_ready;
         if (ks_fire_s) begin
            ks_hs_cnt++;
            if (drop_left > 0) drop_left--;
            else occ++;
         end
         if (in_fire_s) occ--;
         if (occ > max_occ) max_occ = occ;
         if (hold_prev) begin
            check("out_valid_hold", int'(bus.out_valid), 1);
            check("out_data_hold", int'(bus.out_data), int'(hold_data));
         end
         if (bus.out_valid && bus.out_ready) begin
            out_hs_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL out_extra: got %0h expected no byte at %0t", bus.out_data, $time);
            end else begin
               check("out_data", int'(bus.out_data), int'(exp_q.pop_front()));
            end
         end
         hold_prev = bus.out_valid && !bus.out_ready;
         hold_data = bus.out_data;
         if (bus.done) done_cnt++;
      end
   end

   // ---------------- drivers ----------------
   initial begin : ks_driver
      bus.ks_valid = 1'b0;
      bus.ks_data  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (ks_fire_s && ks_src_q.size() > 0) void'(ks_src_q.pop_front());
         if (ks_src_q.size() == 0) bus.ks_valid = 1'b0;
         else if (!(bus.ks_valid && !ks_fire_s))
            bus.ks_valid = gap_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.ks_data = (ks_src_q.size() > 0) ? ks_src_q[0] : 8'h00;
      end
   end

   initial begin : in_driver
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (in_fire_s && in_src_q.size() > 0) void'(in_src_q.pop_front());
         if (in_src_q.size() == 0) bus.in_valid = 1'b0;
         else if (!(bus.in_valid && !in_fire_s))
            bus.in_valid = gap_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.in_data = (in_src_q.size() > 0) ? in_src_q[0] : 8'h00;
      end
   end

   initial begin : out_ready_driver
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- reference model helpers ----------------
   task automatic load_msg(input logic [7:0] pt[$], input logic [7:0] ks[$],
                           input logic [7:0] expv[$], input bit add_drop);
      if (add_drop) for (int i = 0; i < TB_DROP; i++) ks_src_q.push_back(8'($urandom));
      foreach (ks[i])   ks_src_q.push_back(ks[i]);
      foreach (pt[i])   in_src_q.push_back(pt[i]);
      foreach (expv[i]) exp_q.push_back(expv[i]);
   endtask

   task automatic load_random(input int len);
      logic [7:0] pt[$], ks[$], ex[$];
      for (int i = 0; i < len; i++) begin
         pt.push_back(8'($urandom));
         ks.push_back(8'($urandom));
         ex.push_back(pt[i] ^ ks[i]);
      end
      load_msg(pt, ks, ex, 1'b1);
   endtask

   task automatic flush_all();
      exp_q.delete();
      ks_src_q.delete();
      in_src_q.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ks_ready"},  int'(bus.ks_ready), 0);
      check({tag, "_in_ready"},  int'(bus.in_ready), 0);
      check({tag, "_out_valid"}, int'(bus.out_valid), 0);
      check({tag, "_out_data"},  int'(bus.out_data), 0);
      check({tag, "_busy"},      int'(bus.busy), 0);
      check({tag, "_done"},      int'(bus.done), 0);
   endtask

   task automatic start_msg(input int len);
      drop_left = TB_DROP;
      occ = 0;
      @(posedge clk);
      #2;
      bus.msg_len = LEN_W'(len);
      bus.start   = 1'b1;
      @(posedge clk);
      #2;
      bus.start   = 1'b0;
      bus.msg_len = LEN_W'($urandom);
   endtask

   task automatic run_msg(input int len, input string tag);
      int d0, k0, waited;
      d0 = done_cnt;
      k0 = ks_hs_cnt;
      start_msg(len);
      waited = 0;
      while (done_cnt == d0 && waited < 4000) begin
         @(negedge clk);
         waited++;
      end
      if (done_cnt == d0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done expected done within 4000 cycles", tag);
         rst_n = 1'b0;
         flush_all();
         repeat (2) @(posedge clk);
         #3 rst_n = 1'b1;
      end else begin
         @(negedge clk);
         @(negedge clk);
         check({tag, "_done_once"}, done_cnt - d0, 1);
         check({tag, "_busy_after"}, int'(bus.busy), 0);
         check({tag, "_exp_left"}, exp_q.size(), 0);
         check({tag, "_ks_hs"}, ks_hs_cnt - k0, len + TB_DROP);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got no finish expected finish before 500000 ns");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin : stimulus
      logic [7:0] pt[$], ks[$], ct[$];
      int d0, o0, k, first_k, waited;
      bit any_ready;

      bus.start   = 1'b0;
      bus.msg_len = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      #2 rst_n = 1'b1;

      // Known vector and its decrypt round trip
      pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
      ks = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
      ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
      load_msg(pt, ks, ct, 1'b1);
      run_msg(9, "known");
      load_msg(ct, ks, pt, 1'b1);
      run_msg(9, "decrypt");

      // Backpressure with gapped keystream
      bp_mode  = 1;
      gap_mode = 1;
      max_occ  = 0;
      load_random(16);
      run_msg(16, "backpressure");
      check("fifo_max_occ_ok", int'(max_occ <= FIFO_DEPTH), 1);
      bp_mode  = 0;
      gap_mode = 0;

      // Zero-length message
      d0 = done_cnt;
      any_ready = 0;
      first_k = 0;
      @(posedge clk);
      #2;
      bus.msg_len = '0;
      bus.start   = 1'b1;
      @(negedge clk);
      k = 1;
      if (bus.ks_ready || bus.in_ready) any_ready = 1;
      @(posedge clk);
      #2 bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         k++;
         if (bus.ks_ready || bus.in_ready) any_ready = 1;
         if (bus.done && first_k == 0) first_k = k;
      end
      check("len0_done_once", done_cnt - d0, 1);
      check("len0_done_cycle", first_k, 2);
      check("len0_no_ready", int'(any_ready), 0);

      // Reset in the middle of a message
      load_random(16);
      o0 = out_hs_cnt;
      d0 = done_cnt;
      start_msg(16);
      waited = 0;
      while (out_hs_cnt - o0 < 5 && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      check("midreset_reached_5", int'(out_hs_cnt - o0 >= 5), 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      flush_all();
      #1;
      check_idle_outputs("midreset");
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      check("midreset_no_done", done_cnt - d0, 0);
      load_random(3);
      run_msg(3, "after_reset");

`ifdef RC4_DROP_EN
      // Drop variant: first four keystream bytes discarded
      pt = '{8'h50, 8'h6C};
      ks = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hEB, 8'h9F};
      ct = '{8'hBB, 8'hF3};
      load_msg(pt, ks, ct, 1'b0);
      run_msg(2, "drop");
`endif

      // Random messages with random backpressure
      for (int m = 0; m < 4; m++) begin
         int len;
         len = $urandom_range(1, 40);
         bp_mode  = 1'($urandom_range(0, 1));
         gap_mode = 1'($urandom_range(0, 1));
         max_occ  = 0;
         load_random(len);
         run_msg(len, "random");
         check("random_fifo_max_occ_ok", int'(max_occ <= FIFO_DEPTH), 1);
      end
      bp_mode  = 0;
      gap_mode = 0;

      // Longest message the length field allows
      load_random(255);
      run_msg(255, "maxlen");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
